// File: rtl/sfifo_flags_if.sv
// Bundle of the write side, read side and status signals of the single-clock FIFO.
// The master side drives requests and data. The slave side is the FIFO itself.
interface sfifo_flags_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   wr_en;
  logic                   full;
  logic                   almost_full;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   rd_en;
  logic                   empty;
  logic                   almost_empty;
  logic [ADDRESS_WIDTH:0] count;
  logic                   flush;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output data_in, wr_en, rd_en, flush,
    input  full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, wr_en, rd_en, flush,
    output full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sfifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error flags,
// synchronous flush and a selectable standard or first-word-fall-through read port.
module sfifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int FWFT          = 0,
  parameter int AF_THRESH     = (1 << ADDRESS_WIDTH) - 2,
  parameter int AE_THRESH     = 2
) (
  input logic          clk,
  input logic          rst_n,
  sfifo_flags_if.slave fifo
);

  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_C = (ADDRESS_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   AF_C    = (ADDRESS_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDRESS_WIDTH:0]   AE_C    = (ADDRESS_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH:0]   cnt;
  logic [ADDRESS_WIDTH:0]   cnt_nxt;
  logic                     full_r;
  logic                     afull_r;
  logic                     empty_r;
  logic                     aempty_r;
  logic                     ovf_r;
  logic                     udf_r;
  logic                     wr_acc;
  logic                     rd_acc;

  function automatic logic full_of(input logic [ADDRESS_WIDTH:0] c);
    return c == DEPTH_C;
  endfunction

  function automatic logic afull_of(input logic [ADDRESS_WIDTH:0] c);
    return c >= AF_C;
  endfunction

  function automatic logic empty_of(input logic [ADDRESS_WIDTH:0] c);
    return c == '0;
  endfunction

  function automatic logic aempty_of(input logic [ADDRESS_WIDTH:0] c);
    return c <= AE_C;
  endfunction

  // Acceptance uses only the registered flags. A flush discards both requests.
  always_comb begin
    wr_acc  = fifo.wr_en & ~full_r  & ~fifo.flush;
    rd_acc  = fifo.rd_en & ~empty_r & ~fifo.flush;
    cnt_nxt = cnt;
    if (fifo.flush) begin
      cnt_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      cnt_nxt = cnt + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      cnt_nxt = cnt - CNT_ONE;
    end
  end

  // Flags are derived from the next count, so they always agree with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      full_r   <= full_of('0);
      afull_r  <= afull_of('0);
      empty_r  <= empty_of('0);
      aempty_r <= aempty_of('0);
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      full_r   <= full_of(cnt_nxt);
      afull_r  <= afull_of(cnt_nxt);
      empty_r  <= empty_of(cnt_nxt);
      aempty_r <= aempty_of(cnt_nxt);
      if (fifo.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_r  <= 1'b0;
        udf_r  <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        if (fifo.wr_en && full_r)  ovf_r <= 1'b1;
        if (fifo.rd_en && empty_r) udf_r <= 1'b1;
      end
    end
  end

  // Storage holds no reset state, so it maps onto plain dual-port RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= fifo.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Because empty is registered, a word written into an empty FIFO is seen only after the edge.
      assign fifo.data_out = empty_r ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r <= '0;
        end else if (fifo.flush) begin
          dout_r <= '0;
        end else if (rd_acc) begin
          dout_r <= mem[rd_ptr];
        end
      end

      assign fifo.data_out = dout_r;
    end
  endgenerate

  assign fifo.count        = cnt;
  assign fifo.full         = full_r;
  assign fifo.almost_full  = afull_r;
  assign fifo.empty        = empty_r;
  assign fifo.almost_empty = aempty_r;
  assign fifo.overflow     = ovf_r;
  assign fifo.underflow    = udf_r;

endmodule
